shift_sequencer_4bit: RTL

SHIFT_SEQUENCER_4BIT -- requirements
Module: shift_sequencer_4bit

---
 rtl/shift_sequencer_4bit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shift_sequencer_4bit.sv
// Shift sequencer: accepts one 4-bit word plus a shift code and amount,
// applies one shift step per clock in SHIFT, then presents the result in
// DONE until the consumer takes it. op_cnt counts completed handshakes.
module shift_sequencer_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_word,
    input  logic [2:0] in_sel,
    input  logic [1:0] in_amt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_word,
    output logic [7:0] op_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_LSR = 3'b001;
    localparam logic [2:0] SEL_LSL = 3'b010;
    localparam logic [2:0] SEL_CLR = 3'b011;
    localparam logic [2:0] SEL_ROR = 3'b101;
    localparam logic [2:0] SEL_ROL = 3'b110;

    state_t     state_q,  state_d;
    logic [3:0] work_q,   work_d;    // working word for the operation in flight
    logic [2:0] sel_q,    sel_d;     // captured shift code
    logic [1:0] cnt_q,    cnt_d;     // remaining shift steps
    logic [3:0] result_q, result_d;  // last completed result, shown outside DONE
    logic [7:0] op_cnt_q, op_cnt_d;

    // One shift step for a given code; unlisted codes hold the word.
    function automatic logic [3:0] apply_step(input logic [3:0] w, input logic [2:0] sel);
        logic [3:0] r;
        case (sel)
            SEL_LSR: r = {1'b0, w[3:1]};
            SEL_LSL: r = {w[2:0], 1'b0};
            SEL_ROR: r = {w[0], w[3:1]};
            SEL_ROL: r = {w[2:0], w[3]};
            SEL_CLR: r = 4'b0000;
            default: r = w;
        endcase
        return r;
    endfunction

    // Codes that actually move bits and therefore spend time in SHIFT.
    function automatic logic is_shifting(input logic [2:0] sel);
        return (sel == SEL_LSR) || (sel == SEL_LSL) ||
               (sel == SEL_ROR) || (sel == SEL_ROL);
    endfunction

    // Next-state, datapath and counter update.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d  = state_q;
        work_d   = work_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_cnt_d = op_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sel_d = in_sel;
                    cnt_d = in_amt;
                    if (is_shifting(in_sel) && (in_amt != 2'd0)) begin
                        state_d = SHIFT;
                        work_d  = in_word;
                    end else begin
                        // Clear and hold codes, and zero-amount shifts, finish
                        // in a single step straight into DONE.
                        state_d = DONE;
                        work_d  = (in_sel == SEL_CLR) ? 4'b0000 : in_word;
                    end
                end
            end

            SHIFT: begin
                work_d = apply_step(work_q, sel_q);
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d  = IDLE;
                    result_d = work_q;
                    op_cnt_d = op_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= 4'b0000;
            sel_q    <= 3'b000;
            cnt_q    <= 2'd0;
            result_q <= 4'b0000;
            op_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before the edge, independent of statement order.
            state_q  <= state_d;
            work_q   <= work_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // combinationally. out_word shows the live result in DONE and the last
    // completed one elsewhere.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_word  = (state_q == DONE) ? work_q : result_q;
    assign op_cnt    = op_cnt_q;

endmodule
